// File: rtl/uart_transceiver.sv
// Full-duplex UART with configurable width, parity and stop bits.
// Bit timing comes from a per-direction cycle counter on the system clock.
module uart_transceiver #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 2400,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 srst_n,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx_busy,
   output logic                 txd,
   input  logic                 rxd,
   input  logic                 loopback,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err
);

   localparam int C  = CLK_FREQ / BAUD_RATE;
   localparam int CW = $clog2(STOP_BITS * C + 1);
   localparam logic [CW-1:0] C_BIT  = CW'(C - 1);
   localparam logic [CW-1:0] C_HALF = CW'(C / 2 - 1);
   localparam logic [CW-1:0] C_STOP = CW'(STOP_BITS * C - 1);
   localparam logic [CW-1:0] C_ONE  = CW'(1);
   localparam logic [3:0]    C_LAST = 4'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT
   } state_t;

   state_t                r_tx_st;
   logic [CW-1:0]         r_tx_cnt;
   logic [3:0]            r_tx_bit;
   logic [DATA_BITS-1:0]  r_tx_sh;
   logic                  r_tx_par;
   logic                  r_txd;
   logic                  r_tx_busy;
   logic                  w_tx_go;

   assign tx_ready = (r_tx_st == S_IDLE) && srst_n;
   assign tx_busy  = r_tx_busy;
   assign w_tx_go  = tx_valid && tx_ready;
   // Loopback keeps the pin idle so the far end sees no traffic.
   assign txd      = loopback ? 1'b1 : r_txd;

   always_ff @(posedge clk) begin
      if (!srst_n) begin
         r_tx_st   <= S_IDLE;
         r_tx_cnt  <= '0;
         r_tx_bit  <= '0;
         r_tx_sh   <= '0;
         r_tx_par  <= 1'b0;
         r_txd     <= 1'b1;
         r_tx_busy <= 1'b0;
      end else begin
         r_tx_cnt <= r_tx_cnt + C_ONE;
         unique case (r_tx_st)
            S_IDLE: begin
               r_tx_cnt <= '0;
               r_tx_bit <= '0;
               if (w_tx_go) begin
                  r_tx_sh   <= tx_data;
                  r_tx_par  <= (PARITY == 1) ? ~^tx_data : ^tx_data;
                  r_txd     <= 1'b0;
                  r_tx_busy <= 1'b1;
                  r_tx_st   <= S_START;
               end
            end
            S_START: if (r_tx_cnt == C_BIT) begin
               r_tx_cnt <= '0;
               r_txd    <= r_tx_sh[0];
               r_tx_st  <= S_DATA;
            end
            S_DATA: if (r_tx_cnt == C_BIT) begin
               r_tx_cnt <= '0;
               r_tx_bit <= r_tx_bit + 4'd1;
               r_tx_sh  <= r_tx_sh >> 1;
               if (r_tx_bit == C_LAST) begin
                  if (PARITY != 0) begin
                     r_txd   <= r_tx_par;
                     r_tx_st <= S_PARITY;
                  end else begin
                     r_txd   <= 1'b1;
                     r_tx_st <= S_STOP;
                  end
               end else begin
                  r_txd <= r_tx_sh[1];
               end
            end
            S_PARITY: if (r_tx_cnt == C_BIT) begin
               r_tx_cnt <= '0;
               r_txd    <= 1'b1;
               r_tx_st  <= S_STOP;
            end
            S_STOP: if (r_tx_cnt == C_STOP) begin
               r_tx_busy <= 1'b0;
               r_tx_st   <= S_IDLE;
            end
            default: r_tx_st <= S_IDLE;
         endcase
      end
   end

   state_t                r_rx_st;
   logic [CW-1:0]         r_rx_cnt;
   logic [3:0]            r_rx_bit;
   logic [DATA_BITS-1:0]  r_rx_sh;
   logic                  r_rx_par;
   logic                  r_s1, r_s2, r_prev;
   logic [DATA_BITS-1:0]  r_rx_data;
   logic                  r_rx_valid, r_rx_pe, r_rx_fe;
   logic                  w_fall, w_exp;

   assign w_fall        = r_prev & ~r_s2;
   assign w_exp         = (PARITY == 1) ? ~^r_rx_sh : ^r_rx_sh;
   assign rx_data       = r_rx_data;
   assign rx_valid      = r_rx_valid;
   assign rx_parity_err = r_rx_pe;
   assign rx_frame_err  = r_rx_fe;

   always_ff @(posedge clk) begin
      if (!srst_n) begin
         r_s1       <= 1'b1;
         r_s2       <= 1'b1;
         r_prev     <= 1'b1;
         r_rx_st    <= S_IDLE;
         r_rx_cnt   <= '0;
         r_rx_bit   <= '0;
         r_rx_sh    <= '0;
         r_rx_par   <= 1'b0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_rx_pe    <= 1'b0;
         r_rx_fe    <= 1'b0;
      end else begin
         r_s1       <= loopback ? r_txd : rxd;
         r_s2       <= r_s1;
         r_prev     <= r_s2;
         r_rx_valid <= 1'b0;
         r_rx_pe    <= 1'b0;
         r_rx_fe    <= 1'b0;
         r_rx_cnt   <= r_rx_cnt + C_ONE;
         unique case (r_rx_st)
            S_IDLE: begin
               r_rx_cnt <= '0;
               r_rx_bit <= '0;
               if (w_fall) r_rx_st <= S_START;
            end
            S_START: if (r_rx_cnt == C_HALF) begin
               r_rx_cnt <= '0;
               r_rx_st  <= r_s2 ? S_IDLE : S_DATA;
            end
            S_DATA: if (r_rx_cnt == C_BIT) begin
               r_rx_cnt <= '0;
               r_rx_bit <= r_rx_bit + 4'd1;
               r_rx_sh  <= {r_s2, r_rx_sh[DATA_BITS-1:1]};
               if (r_rx_bit == C_LAST)
                  r_rx_st <= (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (r_rx_cnt == C_BIT) begin
               r_rx_cnt <= '0;
               r_rx_par <= r_s2;
               r_rx_st  <= S_STOP;
            end
            S_STOP: if (r_rx_cnt == C_BIT) begin
               r_rx_data  <= r_rx_sh;
               r_rx_valid <= 1'b1;
               r_rx_pe    <= (PARITY != 0) && (r_rx_par != w_exp);
               r_rx_fe    <= ~r_s2;
               r_rx_st    <= r_s2 ? S_IDLE : S_WAIT;
            end
            // A held-low line (break) must return high before re-arming.
            S_WAIT: if (r_s2) r_rx_st <= S_IDLE;
            default: r_rx_st <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver: an 8N1 instance and an 8E1 instance
// sharing clock and reset, C = 10 cycles per bit.
module tb_uart_transceiver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       srst_n;
   logic [7:0] a_tx_data, b_tx_data;
   logic       a_tx_valid, b_tx_valid;
   logic       a_tx_ready, b_tx_ready;
   logic       a_tx_busy, b_tx_busy;
   logic       a_txd, b_txd;
   logic       a_rxd, b_rxd;
   logic       a_loopback, b_loopback;
   logic [7:0] a_rx_data, b_rx_data;
   logic       a_rx_valid, b_rx_valid;
   logic       a_pe_o, b_pe_o, a_fe_o, b_fe_o;

   uart_transceiver #(
      .CLK_FREQ(1_000_000), .BAUD_RATE(100_000),
      .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
   ) u_a (
      .clk(clk), .srst_n(srst_n),
      .tx_data(a_tx_data), .tx_valid(a_tx_valid),
      .tx_ready(a_tx_ready), .tx_busy(a_tx_busy),
      .txd(a_txd), .rxd(a_rxd), .loopback(a_loopback),
      .rx_data(a_rx_data), .rx_valid(a_rx_valid),
      .rx_parity_err(a_pe_o), .rx_frame_err(a_fe_o)
   );

   uart_transceiver #(
      .CLK_FREQ(1_000_000), .BAUD_RATE(100_000),
      .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
   ) u_b (
      .clk(clk), .srst_n(srst_n),
      .tx_data(b_tx_data), .tx_valid(b_tx_valid),
      .tx_ready(b_tx_ready), .tx_busy(b_tx_busy),
      .txd(b_txd), .rxd(b_rxd), .loopback(b_loopback),
      .rx_data(b_rx_data), .rx_valid(b_rx_valid),
      .rx_parity_err(b_pe_o), .rx_frame_err(b_fe_o)
   );

   int n_run = 0;
   int n_fail = 0;
   int a_cnt = 0;
   int b_cnt = 0;
   logic [7:0] a_dat, b_dat;
   logic a_pe, a_fe, b_pe, b_fe;

   always @(posedge clk) begin
      if (a_rx_valid === 1'b1) begin
         a_cnt <= a_cnt + 1;
         a_dat <= a_rx_data;
         a_pe  <= a_pe_o;
         a_fe  <= a_fe_o;
      end
      if (b_rx_valid === 1'b1) begin
         b_cnt <= b_cnt + 1;
         b_dat <= b_rx_data;
         b_pe  <= b_pe_o;
         b_fe  <= b_fe_o;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic [15:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         if (sel) b_rxd = v[i];
         else     a_rxd = v[i];
         repeat (10) tick();
      end
   endtask

   int base;
   logic hi;
   logic [9:0] fa;

   initial begin
      srst_n     = 1'b0;
      a_tx_valid = 1'b1;
      a_tx_data  = 8'hA5;
      b_tx_valid = 1'b0;
      b_tx_data  = 8'h00;
      a_rxd      = 1'b1;
      b_rxd      = 1'b1;
      a_loopback = 1'b0;
      b_loopback = 1'b0;

      // reset held with tx_valid asserted
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_txd", 16'(a_txd), 16'h1);
         chk("rst_busy", 16'(a_tx_busy), 16'h0);
         chk("rst_ready", 16'(a_tx_ready), 16'h0);
      end
      chk("rst_rx_data", 16'(a_rx_data), 16'h0);
      chk("rst_rx_valid", 16'(a_rx_valid), 16'h0);
      chk("rst_pe", 16'(a_pe_o), 16'h0);
      chk("rst_fe", 16'(b_fe_o), 16'h0);
      srst_n = 1'b1;
      #1;
      chk("rel_ready", 16'(a_tx_ready), 16'h1);
      chk("rel_txd", 16'(a_txd), 16'h1);

      // 8N1 frame of 0xA5 accepted on the next edge
      tick();
      a_tx_valid = 1'b0;
      fa = {1'b1, 8'hA5, 1'b0};
      for (int j = 0; j < 10; j++) begin
         for (int c = 0; c < 10; c++) begin
            chk("tx_a5_bit", 16'(a_txd), 16'(fa[j]));
            chk("tx_a5_busy", 16'(a_tx_busy), 16'h1);
            tick();
         end
      end
      chk("tx_done_ready", 16'(a_tx_ready), 16'h1);
      chk("tx_done_busy", 16'(a_tx_busy), 16'h0);
      chk("tx_done_txd", 16'(a_txd), 16'h1);

      // 8E1 loopback of 0x3C
      b_loopback = 1'b1;
      b_tx_data  = 8'h3C;
      b_tx_valid = 1'b1;
      base = b_cnt;
      hi = 1'b1;
      tick();
      b_tx_valid = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (b_txd !== 1'b1) hi = 1'b0;
         tick();
      end
      chk("lb_count", 16'(b_cnt - base), 16'h1);
      chk("lb_data", 16'(b_dat), 16'h3C);
      chk("lb_pe", 16'(b_pe), 16'h0);
      chk("lb_fe", 16'(b_fe), 16'h0);
      chk("lb_pin_high", 16'(hi), 16'h1);
      chk("lb_busy", 16'(b_tx_busy), 16'h0);
      b_loopback = 1'b0;
      repeat (5) tick();

      // 8E1 frame 0x01 with wrong parity bit 0
      base = b_cnt;
      drive(1'b1, 16'h0402, 11);
      repeat (20) tick();
      chk("pe_count", 16'(b_cnt - base), 16'h1);
      chk("pe_data", 16'(b_dat), 16'h01);
      chk("pe_flag", 16'(b_pe), 16'h1);
      chk("pe_fe", 16'(b_fe), 16'h0);

      // 8N1 frame 0x55 with stop bit 0, then line held low
      base = a_cnt;
      drive(1'b0, 16'h00AA, 10);
      repeat (50) tick();
      chk("fe_count", 16'(a_cnt - base), 16'h1);
      chk("fe_data", 16'(a_dat), 16'h55);
      chk("fe_flag", 16'(a_fe), 16'h1);
      chk("fe_pe", 16'(a_pe), 16'h0);
      a_rxd = 1'b1;
      repeat (20) tick();
      chk("brk_no_valid", 16'(a_cnt - base), 16'h1);
      drive(1'b0, 16'h021E, 10);
      repeat (20) tick();
      chk("after_brk_count", 16'(a_cnt - base), 16'h2);
      chk("after_brk_data", 16'(a_dat), 16'h0F);
      chk("after_brk_fe", 16'(a_fe), 16'h0);
      chk("after_brk_pe", 16'(a_pe), 16'h0);

      // 3-cycle glitch is a false start
      base = a_cnt;
      a_rxd = 1'b0;
      repeat (3) tick();
      a_rxd = 1'b1;
      repeat (30) tick();
      chk("glitch", 16'(a_cnt - base), 16'h0);

      // reset in the middle of a 0xFF transmission
      a_tx_data  = 8'hFF;
      a_tx_valid = 1'b1;
      tick();
      a_tx_valid = 1'b0;
      chk("ff_busy", 16'(a_tx_busy), 16'h1);
      chk("ff_start", 16'(a_txd), 16'h0);
      repeat (35) tick();
      srst_n = 1'b0;
      tick();
      chk("mid_rst_txd", 16'(a_txd), 16'h1);
      chk("mid_rst_busy", 16'(a_tx_busy), 16'h0);
      tick();
      srst_n = 1'b1;
      #1;
      chk("post_rst_ready", 16'(a_tx_ready), 16'h1);
      chk("post_rst_txd", 16'(a_txd), 16'h1);
      tick();
      chk("post_rst_busy", 16'(a_tx_busy), 16'h0);
      chk("post_rst_txd2", 16'(a_txd), 16'h1);

      // reset in the middle of a received frame
      base = b_cnt;
      b_rxd = 1'b0;
      repeat (40) tick();
      srst_n = 1'b0;
      b_rxd  = 1'b1;
      repeat (2) tick();
      srst_n = 1'b1;
      repeat (120) tick();
      chk("rx_rst_abort", 16'(b_cnt - base), 16'h0);
      chk("rx_rst_data", 16'(b_rx_data), 16'h0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
